// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter: shares the single-port program BRAM between instruction fetch and the data bus
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   if_req/if_addr                  fetch request; if_stall/if_rdata/if_rvalid back to fetch
//   d_ren/d_wen/d_be/d_addr/d_wdata data-bus request; d_stall/d_rdata/d_rvalid back to the bus
//   mem_en/mem_we/mem_addr/mem_wdata BRAM drive; mem_rdata BRAM read data (1-cycle latency)
module prog_mem_arbiter #(
  parameter int ADDR_WIDTH      = 14,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_stall,
  output logic [31:0]           if_rdata,
  output logic                  if_rvalid,
  input  logic                  d_ren,
  input  logic                  d_wen,
  input  logic [3:0]            d_be,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_stall,
  output logic [31:0]           d_rdata,
  output logic                  d_rvalid,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  localparam int SW = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_IF   = 2'd1;
  localparam logic [1:0] RSP_DATA = 2'd2;
  logic [SW-1:0]         streak_q, streak_d;
  logic [1:0]            rsp_q, rsp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                  d_req, d_grant, if_grant, at_max;
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_WIDTH+2], d_addr[1:0], d_addr[31:ADDR_WIDTH+2]};
  always_comb begin
    d_req      = d_ren | d_wen;
    at_max     = streak_q == SW'(DATA_STREAK_MAX);
    // data wins contention until it has won DATA_STREAK_MAX times in a row against a waiting fetch
    d_grant    = ~reset & d_req & ~(if_req & at_max);
    if_grant   = ~reset & if_req & ~d_grant;
    if_stall   = if_req & ~if_grant;
    d_stall    = d_req & ~d_grant;
    mem_en     = if_grant | d_grant;
    mem_we     = (d_grant & d_wen) ? d_be : 4'b0;
    addr_d     = if_grant ? if_addr[ADDR_WIDTH+1:2] : d_grant ? d_addr[ADDR_WIDTH+1:2] : addr_q;
    wdata_d    = mem_en ? d_wdata : wdata_q;
    mem_addr   = reset ? '0 : addr_d;
    mem_wdata  = reset ? '0 : wdata_d;
    // response side is gated by reset so a read granted just before reset is dropped
    if_rvalid  = ~reset & (rsp_q == RSP_IF);
    d_rvalid   = ~reset & (rsp_q == RSP_DATA);
    if_rdata_d = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata_d  = d_rvalid ? mem_rdata : d_rdata_q;
    if_rdata   = reset ? '0 : if_rdata_d;
    d_rdata    = reset ? '0 : d_rdata_d;
    streak_d   = (if_grant | ~if_req) ? '0 : (d_grant & ~at_max) ? streak_q + SW'(1) : streak_q;
    rsp_d      = if_grant ? RSP_IF : (d_grant & d_ren) ? RSP_DATA : RSP_NONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q   <= '0;
      rsp_q      <= RSP_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      streak_q   <= streak_d;
      rsp_q      <= rsp_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
endmodule
